// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: per channel a synchroniser, a debounce FSM, a clean level
// and single-cycle press/release pulses for the BRAM read/write control FSM.
module btn_debounce_pulse #(
    parameter int unsigned N_BTN       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 2_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_rel,
    output logic             any_press
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
    // The edge that leaves REL/PRESS already samples the new level, so it counts as the
    // first stable cycle; the wait state accepts once DB_CYCLES-1 further samples agree.
    localparam int unsigned ACCEPT_AT  = (DB_CYCLES > 1) ? DB_CYCLES - 2 : 0;
    localparam logic [CNT_W-1:0] ACCEPT_CNT = CNT_W'(ACCEPT_AT);
    localparam bit DB_ONE = (DB_CYCLES == 1);

    typedef enum logic [1:0] {
        REL,
        WAIT_P,
        PRESS,
        WAIT_R
    } state_e;

    logic [N_BTN-1:0] accept_press;
    logic             any_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_e                 state_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   level_q;
        logic                   press_q;
        logic                   rel_q;
        logic                   stable_p;
        logic                   stable_r;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn[i]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        always_comb begin
            stable_p = 1'b0;
            stable_r = 1'b0;
            if (DB_ONE) begin
                stable_p = (state_q == REL)   && s;
                stable_r = (state_q == PRESS) && !s;
            end else begin
                stable_p = (state_q == WAIT_P) && s  && (cnt_q == ACCEPT_CNT);
                stable_r = (state_q == WAIT_R) && !s && (cnt_q == ACCEPT_CNT);
            end
        end

        assign accept_press[i] = stable_p;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= REL;
                cnt_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                unique case (state_q)
                    REL: begin
                        if (stable_p) begin
                            state_q <= PRESS;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else if (s) begin
                            state_q <= WAIT_P;
                            cnt_q   <= '0;
                        end
                    end
                    WAIT_P: begin
                        if (!s) begin
                            state_q <= REL;
                            cnt_q   <= '0;
                        end else if (stable_p) begin
                            state_q <= PRESS;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    PRESS: begin
                        if (stable_r) begin
                            state_q <= REL;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                            rel_q   <= 1'b1;
                        end else if (!s) begin
                            state_q <= WAIT_R;
                            cnt_q   <= '0;
                        end
                    end
                    WAIT_R: begin
                        if (s) begin
                            state_q <= PRESS;
                            cnt_q   <= '0;
                        end else if (stable_r) begin
                            state_q <= REL;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                            rel_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= REL;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i] = level_q;
        assign btn_press[i] = press_q;
        assign btn_rel[i]   = rel_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |accept_press;
        end
    end

    assign any_press = any_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench for btn_debounce_pulse: each stimulus pushes the pulse it should
// cause (cycle, press, release); a negedge monitor pops and compares, and flags strays.
module tb_btn_debounce_pulse;

    localparam int unsigned N   = 4;
    localparam int unsigned SYN = 2;
    localparam int unsigned DB  = 4;
    localparam int unsigned LAT = SYN + DB;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_rel;
    logic         any_press;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    typedef struct {
        int unsigned  cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } evt_t;

    evt_t         sb[$];
    logic [N-1:0] lvl_exp = '0;

    btn_debounce_pulse #(
        .N_BTN      (N),
        .SYNC_STAGES(SYN),
        .DB_CYCLES  (DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_rel  (btn_rel),
        .any_press(any_press)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge right after driving btn: first edge that sees it is edge 0.
    task automatic expect_evt(input logic [N-1:0] p, input logic [N-1:0] r);
        evt_t e;
        e.cyc   = cyc + LAT;
        e.press = p;
        e.rel   = r;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        evt_t e;
        if (!reset) lvl_exp = '0;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("press", 32'(btn_press), 32'(e.press));
            chk("rel",   32'(btn_rel),   32'(e.rel));
            chk("any",   32'(any_press), 32'(|e.press));
            lvl_exp = (lvl_exp | e.press) & ~e.rel;
            chk("level", 32'(btn_level), 32'(lvl_exp));
        end else begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("evt_timeout", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (btn_press != '0 || btn_rel != '0 || any_press)
                chk("spurious", 32'({btn_press, btn_rel, any_press}), 32'(0));
        end
    end

    initial begin
        reset = 1'b0;
        btn   = '0;

        // 1: reset held, buttons toggling
        for (int i = 0; i < 6; i++) begin
            btn = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            tick(1);
            chk("rst_out", 32'({btn_level, btn_press, btn_rel, any_press}), 32'(0));
        end
        btn = '0;
        tick(1);
        reset = 1'b1;
        tick(8);
        chk("post_rst_level", 32'(btn_level), 32'(0));

        // 2: single clean press on btn[0], latency and one-cycle pulse
        btn[0] = 1'b1;
        expect_evt(4'b0001, 4'b0000);
        tick(LAT - 1);
        chk("t2_early_level", 32'(btn_level[0]), 32'(0));
        tick(2);
        chk("t2_press_gone", 32'(btn_press[0]), 32'(0));
        chk("t2_level_held", 32'(btn_level[0]), 32'(1));
        btn[0] = 1'b0;
        expect_evt(4'b0000, 4'b0001);
        tick(LAT + 4);

        // 3: bounce on btn[1] then steady press
        btn[1] = 1'b1; tick(1);
        btn[1] = 1'b0; tick(1);
        btn[1] = 1'b1; tick(1);
        btn[1] = 1'b0; tick(1);
        btn[1] = 1'b1;
        expect_evt(4'b0010, 4'b0000);
        tick(LAT + 4);
        btn[1] = 1'b0;
        expect_evt(4'b0000, 4'b0010);
        tick(LAT + 4);

        // glitch one cycle shorter than the debounce window, from released
        btn[1] = 1'b1; tick(DB - 1);
        btn[1] = 1'b0; tick(LAT + 6);
        chk("glitch_rel_level", 32'(btn_level), 32'(0));

        // 4: long hold on btn[3] with a short drop-out, then release
        btn[3] = 1'b1;
        expect_evt(4'b1000, 4'b0000);
        tick(50);
        btn[3] = 1'b0; tick(2);
        btn[3] = 1'b1; tick(48);
        chk("t4_held_level", 32'(btn_level[3]), 32'(1));
        btn[3] = 1'b0;
        expect_evt(4'b0000, 4'b1000);
        tick(LAT + 4);

        // 5: simultaneous press / release on btn[0] and btn[2]
        btn = 4'b0101;
        expect_evt(4'b0101, 4'b0000);
        tick(LAT + 4);
        btn = 4'b0000;
        expect_evt(4'b0000, 4'b0101);
        tick(LAT + 4);

        // 6: reset mid-debounce on btn[2], then re-acceptance of the held press
        btn[2] = 1'b1;
        tick(3);
        reset = 1'b0;
        #1;
        chk("t6_rst_out", 32'({btn_level, btn_press, btn_rel, any_press}), 32'(0));
        tick(2);
        reset = 1'b1;
        expect_evt(4'b0100, 4'b0000);
        tick(LAT + 4);
        btn[2] = 1'b0;
        expect_evt(4'b0000, 4'b0100);
        tick(LAT + 4);

        tick(5);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
